// File: rtl/mem_access_seq.sv
// Single-request memory sequencer: word/byte loads and stores, LDI/STI double access,
// misalignment detection and an optional per-phase response timeout.
module mem_access_seq #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_error,
    output logic [WIDTH-1:0]   mem_address,
    output logic               mem_read,
    output logic               mem_write,
    output logic [WIDTH/8-1:0] mem_wmask,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_resp
);
    localparam int BYTES   = WIDTH / 8;
    localparam int LSB     = $clog2(BYTES);
    localparam int CW      = $clog2(MAX_WAIT + 2);
    localparam int TO_LAST = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

    localparam logic [2:0] OP_LDW  = 3'b000;
    localparam logic [2:0] OP_LDBZ = 3'b001;
    localparam logic [2:0] OP_LDBS = 3'b010;
    localparam logic [2:0] OP_STW  = 3'b011;
    localparam logic [2:0] OP_STB  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_STI  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [LSB-1:0]     lane_q, lane_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]      wait_q, wait_d;

    logic               req_ready_q, rsp_valid_q, rsp_error_q, rsp_error_d;
    logic               mem_read_q, mem_write_q;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BYTES-1:0]   mem_wmask_q, mem_wmask_d;

    logic [7:0]         rbyte;
    logic [BYTES-1:0]   stb_mask;
    logic               word_op, timeout_hit;

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1:LSB], {LSB{1'b0}}};
    endfunction

    always_comb begin
        rbyte    = '0;
        stb_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (lane_q == LSB'(b)) rbyte = mem_rdata[b*8 +: 8];
            stb_mask[b] = (req_addr[LSB-1:0] == LSB'(b));
        end
    end

    assign word_op     = (req_op == OP_LDW) || (req_op == OP_STW) ||
                         (req_op == OP_LDI) || (req_op == OP_STI);
    assign timeout_hit = (MAX_WAIT > 0) && (wait_q == CW'(TO_LAST));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        wait_d        = wait_q;
        rsp_data_d    = '0;
        rsp_error_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_wmask_d   = mem_wmask_q;
        mem_wdata_d   = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    lane_d  = req_addr[LSB-1:0];
                    wdata_d = req_wdata;
                    wait_d  = '0;
                    if (req_op == OP_RSV || (word_op && |req_addr[LSB-1:0])) begin
                        state_d     = RESP;
                        rsp_error_d = 1'b1;
                    end else if (req_op == OP_STW || req_op == OP_STB) begin
                        state_d       = WR;
                        mem_address_d = align(req_addr);
                        mem_wmask_d   = (req_op == OP_STB) ? stb_mask : '1;
                        mem_wdata_d   = (req_op == OP_STB) ? {BYTES{req_wdata[7:0]}} : req_wdata;
                    end else begin
                        state_d       = RD1;
                        mem_address_d = align(req_addr);
                    end
                end
            end
            RD1, RD2, WR: begin
                if (mem_resp) begin
                    wait_d  = '0;
                    state_d = RESP;
                    if (state_q == RD2) begin
                        rsp_data_d = mem_rdata;
                    end else if (state_q == RD1) begin
                        unique case (op_q)
                            OP_LDW:  rsp_data_d = mem_rdata;
                            OP_LDBZ: rsp_data_d = {{(WIDTH-8){1'b0}}, rbyte};
                            OP_LDBS: rsp_data_d = {{(WIDTH-8){rbyte[7]}}, rbyte};
                            default: begin
                                // LDI/STI: the word just read is the pointer for the second phase
                                if (|mem_rdata[LSB-1:0]) begin
                                    rsp_error_d = 1'b1;
                                end else if (op_q == OP_LDI) begin
                                    state_d       = RD2;
                                    mem_address_d = mem_rdata;
                                end else begin
                                    state_d       = WR;
                                    mem_address_d = mem_rdata;
                                    mem_wmask_d   = '1;
                                    mem_wdata_d   = wdata_q;
                                end
                            end
                        endcase
                    end
                end else if (timeout_hit) begin
                    wait_d      = '0;
                    state_d     = RESP;
                    rsp_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            lane_q        <= '0;
            wdata_q       <= '0;
            wait_q        <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_data_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wmask_q   <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            wait_q        <= wait_d;
            req_ready_q   <= (state_d == IDLE);
            rsp_valid_q   <= (state_d == RESP);
            rsp_error_q   <= rsp_error_d;
            rsp_data_q    <= rsp_data_d;
            mem_read_q    <= (state_d == RD1) || (state_d == RD2);
            mem_write_q   <= (state_d == WR);
            mem_address_q <= mem_address_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench: a 16-bit sequencer with MAX_WAIT=4 and a 32-bit one without timeout,
// driven from one vector table plus a hand-written mid-operation reset sequence.
module tb_mem_access_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        mem_resp = 1'b0;

    logic        rdy16, rv16, err16, rd16, wr16;
    logic [15:0] rdata16, addr16, wd16;
    logic [1:0]  wm16;
    logic        rdy32, rv32, err32, rd32, wr32;
    logic [31:0] rdata32, addr32, wd32;
    logic [3:0]  wm32;

    always #5 clk = ~clk;

    mem_access_seq #(.WIDTH(16), .MAX_WAIT(4)) u16 (
        .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rdy16),
        .req_op(req_op), .req_addr(req_addr[15:0]), .req_wdata(req_wdata[15:0]),
        .rsp_valid(rv16), .rsp_data(rdata16), .rsp_error(err16),
        .mem_address(addr16), .mem_read(rd16), .mem_write(wr16), .mem_wmask(wm16),
        .mem_wdata(wd16), .mem_rdata(mem_rdata[15:0]), .mem_resp(mem_resp && !sel));

    mem_access_seq #(.WIDTH(32), .MAX_WAIT(0)) u32 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(rdy32),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv32), .rsp_data(rdata32), .rsp_error(err32),
        .mem_address(addr32), .mem_read(rd32), .mem_write(wr32), .mem_wmask(wm32),
        .mem_wdata(wd32), .mem_rdata(mem_rdata), .mem_resp(mem_resp && sel));

    wire        o_rdy   = sel ? rdy32 : rdy16;
    wire        o_rv    = sel ? rv32  : rv16;
    wire        o_err   = sel ? err32 : err16;
    wire        o_rd    = sel ? rd32  : rd16;
    wire        o_wr    = sel ? wr32  : wr16;
    wire [31:0] o_rdata = sel ? rdata32 : {16'h0, rdata16};
    wire [31:0] o_addr  = sel ? addr32  : {16'h0, addr16};
    wire [31:0] o_wd    = sel ? wd32    : {16'h0, wd16};
    wire [3:0]  o_wm    = sel ? wm32    : {2'b00, wm16};

    typedef struct {
        bit          sel;
        logic [2:0]  op;
        logic [31:0] addr, wdata, rd1, rd2;
        int          dly;
        int          lat;
        logic [31:0] data;
        bit          err;
        int          nrd, nwr;
        logic [31:0] a0, a1;
        logic [3:0]  wm;
        logic [31:0] wd;
        int          rdcyc;
    } vec_t;

    vec_t vecs[$];
    int   errs = 0, checks = 0;
    int   r_lat, r_nrd, r_nwr, r_rdcyc, r_both;
    logic [31:0] r_data, r_a0, r_a1, r_wd;
    logic [3:0]  r_wm;
    bit   r_err, r_rv_after, r_rdy_after;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Acts as the memory: answers each phase after v.dly wait cycles (rd1 then rd2).
    task automatic run_txn(input vec_t v);
        int  t, w, ph;
        bit  adv, done;
        r_lat = 0; r_data = '0; r_err = 0; r_nrd = 0; r_nwr = 0; r_a0 = '0; r_a1 = '0;
        r_wm = '0; r_wd = '0; r_rdcyc = 0; r_both = 0;
        @(negedge clk);
        sel = v.sel;
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        t = 1; w = 0; ph = 0; adv = 0; done = 0;
        while (!done && t < 60) begin
            if (adv) begin ph++; w = 0; adv = 0; end
            if (o_rd && o_wr) r_both++;
            if (o_rd || o_wr) begin
                if (w == 0) begin
                    if (ph == 0) r_a0 = o_addr; else r_a1 = o_addr;
                    if (o_rd) r_nrd++;
                    else begin r_nwr++; r_wm = o_wm; r_wd = o_wd; end
                end
                if (o_rd) r_rdcyc++;
                if (w == v.dly) begin
                    mem_resp = 1'b1; mem_rdata = (ph == 0) ? v.rd1 : v.rd2; adv = 1;
                end else mem_resp = 1'b0;
                w++;
            end else mem_resp = 1'b0;
            if (o_rv) begin
                done = 1; r_lat = t; r_data = o_rdata; r_err = o_err;
            end else begin
                @(negedge clk); t++;
            end
        end
        mem_resp = 1'b0;
        chk("rsp_valid seen within bound", 32'(done), 32'd1);
        @(negedge clk);
        r_rv_after  = o_rv;
        r_rdy_after = o_rdy;
    endtask

    function automatic vec_t mk(bit s, logic [2:0] op, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rd1, logic [31:0] rd2, int dly, int lat,
                                logic [31:0] data, bit err, int nrd, int nwr,
                                logic [31:0] a0, logic [31:0] a1, logic [3:0] wm,
                                logic [31:0] wd, int rdcyc);
        vec_t v;
        v.sel = s; v.op = op; v.addr = addr; v.wdata = wdata; v.rd1 = rd1; v.rd2 = rd2;
        v.dly = dly; v.lat = lat; v.data = data; v.err = err; v.nrd = nrd; v.nwr = nwr;
        v.a0 = a0; v.a1 = a1; v.wm = wm; v.wd = wd; v.rdcyc = rdcyc;
        return v;
    endfunction

    initial begin
        //           sel op    addr      wdata     rd1       rd2      dly lat data      err nrd nwr a0      a1      wm   wd        rdcyc
        vecs.push_back(mk(0, 3'd2, 32'h3001, 32'h0,    32'h80FF, 32'h0,    2, 4, 32'hFF80, 0, 1, 0, 32'h3000, 32'h0, 4'h0, 32'h0, 3));
        vecs.push_back(mk(0, 3'd4, 32'h0041, 32'h12A5, 32'h0,    32'h0,    0, 2, 32'h0,    0, 0, 1, 32'h0040, 32'h0, 4'h2, 32'hA5A5, 0));
        vecs.push_back(mk(0, 3'd3, 32'h0043, 32'h1111, 32'h0,    32'h0,    0, 1, 32'h0,    1, 0, 0, 32'h0,    32'h0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 3'd5, 32'h0100, 32'h0,    32'h2000, 32'hBEEF, 0, 3, 32'hBEEF, 0, 2, 0, 32'h0100, 32'h2000, 4'h0, 32'h0, 2));
        vecs.push_back(mk(0, 3'd6, 32'h0200, 32'h1234, 32'h2001, 32'h0,    0, 2, 32'h0,    1, 1, 0, 32'h0200, 32'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 3'd0, 32'h0010, 32'h0,    32'h7777, 32'h0,   99, 5, 32'h0,    1, 1, 0, 32'h0010, 32'h0, 4'h0, 32'h0, 4));
        vecs.push_back(mk(0, 3'd0, 32'h0010, 32'h0,    32'h5A5A, 32'h0,    3, 5, 32'h5A5A, 0, 1, 0, 32'h0010, 32'h0, 4'h0, 32'h0, 4));
        vecs.push_back(mk(0, 3'd0, 32'h0022, 32'h0,    32'h1357, 32'h0,    0, 2, 32'h1357, 0, 1, 0, 32'h0022, 32'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(0, 3'd1, 32'h0022, 32'h0,    32'h80FF, 32'h0,    1, 3, 32'h00FF, 0, 1, 0, 32'h0022, 32'h0, 4'h0, 32'h0, 2));
        vecs.push_back(mk(0, 3'd3, 32'h0030, 32'hCAFE, 32'h0,    32'h0,    1, 3, 32'h0,    0, 0, 1, 32'h0030, 32'h0, 4'h3, 32'hCAFE, 0));
        vecs.push_back(mk(0, 3'd6, 32'h0100, 32'h4321, 32'h0400, 32'h0,    0, 3, 32'h0,    0, 1, 1, 32'h0100, 32'h0400, 4'h3, 32'h4321, 1));
        vecs.push_back(mk(0, 3'd7, 32'h0000, 32'h0,    32'h0,    32'h0,    0, 1, 32'h0,    1, 0, 0, 32'h0,    32'h0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 3'd5, 32'h0101, 32'h0,    32'h0,    32'h0,    0, 1, 32'h0,    1, 0, 0, 32'h0,    32'h0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0050, 32'h0,    32'h1234, 32'h0,    0, 2, 32'h0034, 0, 1, 0, 32'h0050, 32'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(1, 3'd1, 32'h7,    32'h0,    32'h89ABCDEF, 32'h0, 0, 2, 32'h89,  0, 1, 0, 32'h4,    32'h0, 4'h0, 32'h0, 1));
        vecs.push_back(mk(1, 3'd7, 32'h0,    32'h0,    32'h0,    32'h0,    0, 1, 32'h0,    1, 0, 0, 32'h0,    32'h0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd4, 32'h6,    32'hC3,   32'h0,    32'h0,    0, 2, 32'h0,    0, 0, 1, 32'h4,    32'h0, 4'h4, 32'hC3C3C3C3, 0));
        vecs.push_back(mk(1, 3'd0, 32'h2,    32'h0,    32'h0,    32'h0,    0, 1, 32'h0,    1, 0, 0, 32'h0,    32'h0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(1, 3'd2, 32'h5,    32'h0,    32'h00008000, 32'h0, 0, 2, 32'hFFFFFF80, 0, 1, 0, 32'h4, 32'h0, 4'h0, 32'h0, 1));

        // Reset state of both instances
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("reset[%0d] req_ready", s), 32'(o_rdy), 32'd1);
            chk($sformatf("reset[%0d] outs", s),
                {o_rv, o_err, o_rd, o_wr, o_wm} | o_rdata | o_addr | o_wd, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i]);
            chk($sformatf("v%0d latency", i), 32'(r_lat),   32'(vecs[i].lat));
            chk($sformatf("v%0d rsp_data", i), r_data,      vecs[i].data);
            chk($sformatf("v%0d rsp_error", i), 32'(r_err), 32'(vecs[i].err));
            chk($sformatf("v%0d reads", i),   32'(r_nrd),   32'(vecs[i].nrd));
            chk($sformatf("v%0d writes", i),  32'(r_nwr),   32'(vecs[i].nwr));
            chk($sformatf("v%0d addr0", i),   r_a0,         vecs[i].a0);
            chk($sformatf("v%0d addr1", i),   r_a1,         vecs[i].a1);
            chk($sformatf("v%0d wmask", i),   32'(r_wm),    32'(vecs[i].wm));
            chk($sformatf("v%0d wdata", i),   r_wd,         vecs[i].wd);
            chk($sformatf("v%0d rd cycles", i), 32'(r_rdcyc), 32'(vecs[i].rdcyc));
            chk($sformatf("v%0d rd&wr", i),   32'(r_both),  32'd0);
            chk($sformatf("v%0d rsp one-shot", i), 32'(r_rv_after), 32'd0);
            chk($sformatf("v%0d ready after", i), 32'(r_rdy_after), 32'd1);
        end

        // Reset during RD2 of an LDI: read must drop without a clock edge
        @(negedge clk);
        sel = 1'b0;
        req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h0100; req_wdata = '0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_resp = 1'b1; mem_rdata = 32'h2000;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("ldi rd2 mem_read", 32'(o_rd), 32'd1);
        chk("ldi rd2 address", o_addr, 32'h2000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async reset mem_read", 32'(o_rd), 32'd0);
        chk("async reset req_ready", 32'(o_rdy), 32'd1);
        chk("async reset rsp_valid", 32'(o_rv), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int rv_seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (o_rv) rv_seen++;
            end
            chk("no rsp for aborted cmd", 32'(rv_seen), 32'd0);
        end
        run_txn(mk(0, 3'd0, 32'h0040, 32'h0, 32'h9876, 32'h0, 1, 3, 32'h9876, 0, 1, 0,
                   32'h0040, 32'h0, 4'h0, 32'h0, 2));
        chk("post-reset LDW latency", 32'(r_lat), 32'd3);
        chk("post-reset LDW data", r_data, 32'h9876);
        chk("post-reset LDW error", 32'(r_err), 32'd0);
        chk("post-reset LDW addr", r_a0, 32'h0040);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised successor to the MAR/MDR memory path of the multicycle LC-3b datapath.
- A single-request memory sequencer. It accepts one load/store command, drives the memory handshake, and returns one response pulse.
- Adds the following over the existing path:
  - configurable word width and byte lanes
  - sign/zero-extended byte loads
  - hardware indirect (LDI/STI) double access
  - misalignment detection
  - optional response timeout
- Sits between the control FSM/datapath and the memory port; replaces the marmux/mdrmux byte logic.

Parameters:
- WIDTH, 16, data and address width in bits; must be a multiple of 8, at least 16, and a power of two. BYTES = WIDTH/8; LSB = log2(BYTES).
- MAX_WAIT, 0, maximum cycles one memory phase may wait for mem_resp; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  command present.
- req_ready  out  1  sequencer can accept a command.
- req_op  in  3  000 LDW, 001 LDB zero-ext, 010 LDB sign-ext, 011 STW, 100 STB, 101 LDI, 110 STI, 111 reserved.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; STB uses [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  WIDTH  load result; 0 for stores and errors.
- rsp_error  out  1  misaligned, reserved op, or timeout.
- mem_address  out  WIDTH  word-aligned address; low LSB bits are always 0.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_wmask  out  BYTES  byte-lane write enables.
- mem_wdata  out  WIDTH  write data.
- mem_rdata  in  WIDTH  read data; valid when mem_resp=1.
- mem_resp  in  1  memory completion.

Behaviour:
- All outputs are registered.
- Reset, asynchronous at any time including mid-operation:
  - state goes to IDLE
  - req_ready=1
  - every other output is 0, and mem_read/mem_write drop immediately
  - no response is emitted for an aborted command
- States: IDLE, RD1, RD2, WR, RESP.
- req_ready=1 only in IDLE. A command is accepted on the edge where req_valid & req_ready; req_op, req_addr and req_wdata are captured on that edge.
- Decode at accept:
  - Reserved op, or a word op (LDW/STW/LDI/STI) with req_addr[LSB-1:0]!=0: go to RESP with rsp_error=1 and no memory access.
  - LDW, LDB, LDI, STI: go to RD1.
  - STW, STB: go to WR.
- RD1/RD2/WR:
  - mem_read (RD) or mem_write (WR) is held at 1 with stable mem_address, mem_wdata and mem_wmask until the edge that samples mem_resp=1.
  - mem_resp seen in IDLE or RESP is ignored.
- RD1 on mem_resp:
  - LDW: rsp_data=mem_rdata.
  - LDB: selects lane addr[LSB-1:0], then zero- or sign-extends it to WIDTH.
  - LDI: captures mem_rdata as the pointer, then goes to RD2.
  - STI: captures mem_rdata as the pointer, then goes to WR.
  - A misaligned pointer goes to RESP with error and no second access.
- RD2 on mem_resp: rsp_data=mem_rdata.
- WR:
  - Word: mem_wmask all ones, mem_wdata=req_wdata.
  - STB: mem_wmask one-hot at the lane, with req_wdata[7:0] replicated into every lane.
  - On mem_resp go to RESP.
- mem_read and mem_write are never both 1. A phase change deasserts for zero cycles: RD1 to WR switches read to write on the same edge.
- RESP:
  - rsp_valid=1 for exactly one cycle; there is no backpressure.
  - Next state is IDLE, and req_ready returns to 1 the following cycle.
- Latency: LDW/STW with mem_resp in the first request cycle gives rsp_valid 2 cycles after accept. LDI/STI gives 3 cycles minimum. An error at decode gives 1 cycle.
- Timeout (MAX_WAIT>0):
  - A wait counter clears on each phase entry and increments each cycle without mem_resp.
  - When the counter reaches MAX_WAIT, the request is dropped, the state goes to RESP, and rsp_error=1, rsp_data=0.
  - mem_resp on that same edge wins: it is a normal completion.

Test Plan:
1. LDB sign-ext, WIDTH=16, addr 0x3001, memory returns 0x80FF after 2 wait cycles -> mem_address=0x3000, rsp_data=0xFF80, rsp_error=0; rsp_valid 4 cycles after accept.
2. STB addr 0x0041, wdata 0x12A5 -> mem_write=1, mem_wmask=2'b10, mem_wdata=0xA5A5; STW addr 0x0043 -> rsp_error=1 with mem_write never asserted.
3. LDI addr 0x0100: memory word 0x0100=0x2000, word 0x2000=0xBEEF -> two reads at 0x0100 then 0x2000, rsp_data=0xBEEF; STI with pointer 0x2001 -> error after one read.
4. MAX_WAIT=4, mem_resp held 0 -> mem_read high exactly 4 cycles, then rsp_valid=1, rsp_error=1, rsp_data=0; separately, mem_resp on cycle 4 -> normal completion.
5. Reset asserted mid-RD2 of an LDI -> mem_read=0 with no clock edge needed, no rsp_valid, req_ready=1; a new LDW after release completes normally.
6. WIDTH=32, LDB zero-ext addr 0x0000_0007, rdata 0x89AB_CDEF -> mem_address=0x0000_0004, rsp_data=0x0000_0089; req_op=111 -> rsp_error=1 one cycle after accept.
